// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator scheduler and door block: state encoding,
// travel direction codes and floor index width.
package elevador_pkg;

    localparam int FLOOR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOVE_UP   = 3'd1,
        ST_MOVE_DOWN = 3'd2,
        ST_DOOR_REQ  = 3'd3,
        ST_DOOR_WAIT = 3'd4,
        ST_ESTOP     = 3'd5
    } elev_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Neighbouring floor in the given direction; callers guarantee no wrap.
    function automatic logic [FLOOR_W-1:0] floor_step(input logic [FLOOR_W-1:0] f,
                                                       input logic             up);
        if (up == DIR_UP) begin
            floor_step = f + {{(FLOOR_W-1){1'b0}}, 1'b1};
        end else begin
            floor_step = f - {{(FLOOR_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/elevador_scheduler_scan.sv
// elev_req_scan: classifies latched requests relative to an evaluation floor and
// reports whether any lie ahead of / behind the last travel direction.
module elev_req_scan
    import elevador_pkg::*;
#(
    parameter int NFLOORS = 5
) (
    input  logic [NFLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               dir,
    output logic               req_here,
    output logic               req_above,
    output logic               req_below,
    output logic               req_ahead,
    output logic               req_behind
);

    // Reduce the pending vector into here/above/below relative to floor
    always_comb begin
        req_here  = 1'b0;
        req_above = 1'b0;
        req_below = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            req_here  = req_here  | (pending[i] & (i == int'(floor)));
            req_above = req_above | (pending[i] & (i >  int'(floor)));
            req_below = req_below | (pending[i] & (i <  int'(floor)));
        end
        req_ahead  = (dir == DIR_UP) ? req_above : req_below;
        req_behind = (dir == DIR_UP) ? req_below : req_above;
    end

endmodule

// File: rtl/elevador_scheduler.sv
// SCAN-order floor scheduler for the 5-floor elevator with door handshake and timeout.
// Optional emergency stop is built when ESTOP_EN is defined.
module elevador_scheduler
    import elevador_pkg::*;
#(
    parameter int NFLOORS      = 5,
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TIMEOUT = 32
) (
    input  logic               FSMclk,
    input  logic               deb_rst,
    input  logic [NFLOORS-1:0] call_req,
    input  logic               door_done,
`ifdef ESTOP_EN
    input  logic               estop,
    output logic               estop_active,
`endif
    output logic               door_open,
    output logic [FLOOR_W-1:0] floor_cur,
    output logic [NFLOORS-1:0] pending,
    output logic               moving_up,
    output logic               moving_down,
    output logic               door_fault
);

    localparam int TW = $clog2(TRAVEL_TICKS + 1);
    localparam int WW = $clog2(DOOR_TIMEOUT + 1);
    localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [WW-1:0]      WAIT_LAST   = WW'(DOOR_TIMEOUT - 1);
    localparam logic [NFLOORS-1:0] FLOOR0_BIT  = {{(NFLOORS-1){1'b0}}, 1'b1};

    elev_state_t        state_r, state_nxt_s;
    logic               dir_r, dir_nxt_s;
    logic [TW-1:0]      travel_cnt_r, travel_nxt_s;
    logic [WW-1:0]      wait_cnt_r, wait_nxt_s;
    logic [FLOOR_W-1:0] floor_nxt_s, scan_floor_s;
    logic [NFLOORS-1:0] pending_nxt_s, set_s, here_bit_s, next_bit_s;
    logic               fault_nxt_s, estop_s;
    logic               req_here_s, req_above_s, req_below_s, req_ahead_s, req_behind_s;

`ifdef ESTOP_EN
    assign estop_s = estop;
`else
    assign estop_s = 1'b0;
`endif

    // While travelling, decisions are made for the floor being arrived at
    always_comb begin
        case (state_r)
            ST_MOVE_UP:   scan_floor_s = floor_step(floor_cur, DIR_UP);
            ST_MOVE_DOWN: scan_floor_s = floor_step(floor_cur, DIR_DOWN);
            default:      scan_floor_s = floor_cur;
        endcase
    end

    elev_req_scan #(.NFLOORS(NFLOORS)) u_scan (
        .pending    (pending),
        .floor      (scan_floor_s),
        .dir        (dir_r),
        .req_here   (req_here_s),
        .req_above  (req_above_s),
        .req_below  (req_below_s),
        .req_ahead  (req_ahead_s),
        .req_behind (req_behind_s)
    );

    // Next-state, position, direction and counter logic
    always_comb begin
        state_nxt_s  = state_r;
        floor_nxt_s  = floor_cur;
        dir_nxt_s    = dir_r;
        travel_nxt_s = travel_cnt_r;
        wait_nxt_s   = {WW{1'b0}};
        fault_nxt_s  = door_fault;
        if (estop_s) begin
            state_nxt_s = ST_ESTOP;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    travel_nxt_s = {TW{1'b0}};
                    if (req_here_s) begin
                        state_nxt_s = ST_DOOR_REQ;
                    end else if (req_above_s) begin
                        state_nxt_s = ST_MOVE_UP;
                        dir_nxt_s   = DIR_UP;
                    end else if (req_below_s) begin
                        state_nxt_s = ST_MOVE_DOWN;
                        dir_nxt_s   = DIR_DOWN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_MOVE_UP, ST_MOVE_DOWN: begin
                    if (travel_cnt_r == TRAVEL_LAST) begin
                        travel_nxt_s = {TW{1'b0}};
                        floor_nxt_s  = scan_floor_s;
                        if (req_here_s) begin
                            state_nxt_s = ST_DOOR_REQ;
                        end else if (req_ahead_s) begin
                            state_nxt_s = state_r;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        travel_nxt_s = travel_cnt_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DOOR_REQ: begin
                    travel_nxt_s = {TW{1'b0}};
                    state_nxt_s  = ST_DOOR_WAIT;
                end
                ST_DOOR_WAIT: begin
                    if (door_done) begin
                        if (req_ahead_s) begin
                            state_nxt_s = (dir_r == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
                        end else if (req_behind_s) begin
                            dir_nxt_s   = ~dir_r;
                            state_nxt_s = (dir_r == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        fault_nxt_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        wait_nxt_s = wait_cnt_r + {{(WW-1){1'b0}}, 1'b1};
                    end
                end
                // Leaving emergency stop (or any illegal code) resumes from IDLE
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Request latch: calls for the floor being served are absorbed, clear beats set
    always_comb begin
        here_bit_s = FLOOR0_BIT << floor_cur;
        next_bit_s = FLOOR0_BIT << floor_nxt_s;
        if ((state_r == ST_DOOR_REQ) || (state_r == ST_DOOR_WAIT)) begin
            set_s = call_req & ~here_bit_s;
        end else begin
            set_s = call_req;
        end
        if (state_nxt_s == ST_ESTOP) begin
            pending_nxt_s = {NFLOORS{1'b0}};
        end else if (state_nxt_s == ST_DOOR_REQ) begin
            pending_nxt_s = (pending | set_s) & ~next_bit_s;
        end else begin
            pending_nxt_s = pending | set_s;
        end
    end

    // State and registered outputs; flags decode the next state so they track state_r exactly
    always_ff @(posedge FSMclk or posedge deb_rst) begin
        if (deb_rst) begin
            state_r      <= ST_IDLE;
            dir_r        <= DIR_UP;
            travel_cnt_r <= {TW{1'b0}};
            wait_cnt_r   <= {WW{1'b0}};
            floor_cur    <= {FLOOR_W{1'b0}};
            pending      <= {NFLOORS{1'b0}};
            door_open    <= 1'b0;
            moving_up    <= 1'b0;
            moving_down  <= 1'b0;
            door_fault   <= 1'b0;
`ifdef ESTOP_EN
            estop_active <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            dir_r        <= dir_nxt_s;
            travel_cnt_r <= travel_nxt_s;
            wait_cnt_r   <= wait_nxt_s;
            floor_cur    <= floor_nxt_s;
            pending      <= pending_nxt_s;
            door_open    <= (state_nxt_s == ST_DOOR_REQ);
            moving_up    <= (state_nxt_s == ST_MOVE_UP);
            moving_down  <= (state_nxt_s == ST_MOVE_DOWN);
            door_fault   <= fault_nxt_s;
`ifdef ESTOP_EN
            estop_active <= (state_nxt_s == ST_ESTOP);
`endif
        end
    end

endmodule

// File: tb/tb_elevador_scheduler.sv
// Directed, table-driven bench for elevador_scheduler: one row per FSMclk edge with
// hand-computed outputs, plus hand-written async reset and emergency-stop sequences.
module tb_elevador_scheduler;

    logic       FSMclk = 1'b0;
    logic       deb_rst;
    logic [4:0] call_req;
    logic       door_done;
    logic       door_open;
    logic [2:0] floor_cur;
    logic [4:0] pending;
    logic       moving_up;
    logic       moving_down;
    logic       door_fault;
    logic [11:0] outs;
`ifdef ESTOP_EN
    logic       estop = 1'b0;
    logic       estop_active;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        string      tag;
        logic       rst;
        logic [4:0] call;
        logic       dd;
        logic [11:0] exp;   // {door_open, floor_cur, pending, moving_up, moving_down, door_fault}
    } vec_t;

    vec_t vecs[$];

    elevador_scheduler dut (
        .FSMclk      (FSMclk),
        .deb_rst     (deb_rst),
        .call_req    (call_req),
        .door_done   (door_done),
`ifdef ESTOP_EN
        .estop       (estop),
        .estop_active(estop_active),
`endif
        .door_open   (door_open),
        .floor_cur   (floor_cur),
        .pending     (pending),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_fault  (door_fault)
    );

    always #5 FSMclk = ~FSMclk;

    assign outs = {door_open, floor_cur, pending, moving_up, moving_down, door_fault};

    task automatic add(input string tag, input logic rst, input logic [4:0] call, input logic dd,
                       input logic dopen, input logic [2:0] fl, input logic [4:0] pend,
                       input logic up, input logic dn, input logic flt);
        vec_t v;
        v.tag  = tag;
        v.rst  = rst;
        v.call = call;
        v.dd   = dd;
        v.exp  = {dopen, fl, pend, up, dn, flt};
        vecs.push_back(v);
    endtask

    // Rows after entering a move: 3 counting ticks per floor, intermediate arrivals keep moving
    task automatic add_travel(input string tag, input logic up, input int from, input int hops,
                              input logic [4:0] pend, input logic flt);
        int f;
        f = from;
        for (int h = 0; h < hops; h++) begin
            for (int c = 0; c < 3; c++)
                add(tag, 1'b0, 5'b00000, 1'b0, 1'b0, 3'(f), pend, up, ~up, flt);
            f = up ? f + 1 : f - 1;
            if (h < hops - 1)
                add(tag, 1'b0, 5'b00000, 1'b0, 1'b0, 3'(f), pend, up, ~up, flt);
        end
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [4:0] c, input logic dd);
        call_req  = c;
        door_done = dd;
        @(posedge FSMclk);
        #1;
    endtask

    initial begin
        // 1: call own floor -> door_open two edges later, pending clears
        add("t1_latch",  1'b0, 5'b00001, 1'b0, 1'b0, 3'd0, 5'b00001, 1'b0, 1'b0, 1'b0);
        add("t1_door",   1'b0, 5'b00000, 1'b0, 1'b1, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
        add("t1_wait",   1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
        add("t1_done",   1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
        // 2: floor 0 -> 3, one floor per 4 ticks
        add("t2_latch",  1'b0, 5'b01000, 1'b0, 1'b0, 3'd0, 5'b01000, 1'b0, 1'b0, 1'b0);
        add("t2_start",  1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b01000, 1'b1, 1'b0, 1'b0);
        add_travel("t2_move", 1'b1, 0, 3, 5'b01000, 1'b0);
        add("t2_arrive", 1'b0, 5'b00000, 1'b0, 1'b1, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0);
        add("t2_wait",   1'b0, 5'b00000, 1'b0, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0);
        add("t2_idle",   1'b0, 5'b00000, 1'b1, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0);
        // 3: moving up with {4,0} pending -> serve 4, then reverse to 0
        add("t3_latch",  1'b1, 5'b10000, 1'b0, 1'b0, 3'd0, 5'b10000, 1'b0, 1'b0, 1'b0);
        add("t3_start",  1'b0, 5'b00001, 1'b0, 1'b0, 3'd0, 5'b10001, 1'b1, 1'b0, 1'b0);
        add_travel("t3_up", 1'b1, 0, 4, 5'b10001, 1'b0);
        add("t3_clrwins",1'b0, 5'b10000, 1'b0, 1'b1, 3'd4, 5'b00001, 1'b0, 1'b0, 1'b0);
        add("t3_absorb", 1'b0, 5'b10000, 1'b0, 1'b0, 3'd4, 5'b00001, 1'b0, 1'b0, 1'b0);
        add("t3_reverse",1'b0, 5'b00000, 1'b1, 1'b0, 3'd4, 5'b00001, 1'b0, 1'b1, 1'b0);
        add_travel("t3_down", 1'b0, 4, 4, 5'b00001, 1'b0);
        add("t3_arrive0",1'b0, 5'b00000, 1'b0, 1'b1, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
        // 4: door_done never comes -> fault exactly on the 32nd DOOR_WAIT tick, sticky
        add("t4_wait",   1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++)
            add("t4_nofault", 1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
        add("t4_fault",  1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b1);
        add("t4_sticky", 1'b0, 5'b10000, 1'b0, 1'b0, 3'd0, 5'b10000, 1'b0, 1'b0, 1'b1);
        add("t4_start",  1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b10000, 1'b1, 1'b0, 1'b1);
        add_travel("t4_up", 1'b1, 0, 2, 5'b10000, 1'b1);
        add("t5_at2",    1'b0, 5'b00000, 1'b0, 1'b0, 3'd2, 5'b10000, 1'b1, 1'b0, 1'b1);

        deb_rst   = 1'b0;
        call_req  = 5'b00000;
        door_done = 1'b0;
        #1 deb_rst = 1'b1;
        #1 check("reset", outs, 12'h000);
        @(posedge FSMclk);
        #1 check("reset_held", outs, 12'h000);
        deb_rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                deb_rst = 1'b1;
                #1 deb_rst = 1'b0;
            end
            call_req  = vecs[i].call;
            door_done = vecs[i].dd;
            @(posedge FSMclk);
            #1;
            check($sformatf("%s[%0d]", vecs[i].tag, i), outs, vecs[i].exp);
        end

        // 5: asynchronous reset mid MOVE_UP at floor 2, no clock edge needed
        call_req  = 5'b00000;
        door_done = 1'b0;
        #2 deb_rst = 1'b1;
        #1 check("t5_async", outs, 12'h000);
        @(posedge FSMclk);
        #1 check("t5_held", outs, 12'h000);
        deb_rst = 1'b0;
        tick(5'b00000, 1'b0);
        check("t5_release", outs, 12'h000);

`ifdef ESTOP_EN
        // 6: go to floor 2, head down toward 0, emergency stop mid travel
        tick(5'b00100, 1'b0);
        tick(5'b00000, 1'b0);
        for (int i = 0; i < 8; i++) tick(5'b00000, 1'b0);
        check("t6_at2", outs, {1'b1, 3'd2, 5'b00000, 1'b0, 1'b0, 1'b0});
        tick(5'b00000, 1'b0);
        tick(5'b00000, 1'b1);
        tick(5'b00001, 1'b0);
        tick(5'b00000, 1'b0);
        tick(5'b00000, 1'b0);
        check("t6_down", outs, {1'b0, 3'd2, 5'b00001, 1'b0, 1'b1, 1'b0});
        estop = 1'b1;
        tick(5'b00010, 1'b0);
        check("t6_estop_flag", {11'd0, estop_active}, 12'h001);
        check("t6_estop_outs", outs, {1'b0, 3'd2, 5'b00000, 1'b0, 1'b0, 1'b0});
        tick(5'b00000, 1'b0);
        tick(5'b00000, 1'b0);
        check("t6_frozen", outs, {1'b0, 3'd2, 5'b00000, 1'b0, 1'b0, 1'b0});
        estop = 1'b0;
        tick(5'b00000, 1'b0);
        check("t6_release_flag", {11'd0, estop_active}, 12'h000);
        check("t6_release_outs", outs, {1'b0, 3'd2, 5'b00000, 1'b0, 1'b0, 1'b0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
